// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: PC and inter-stage latch enables/flushes, redirect hold, HALT, stall counter.
// Zero-cycle control from current inputs; only fsm, pending-redirect and stall count are registered.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dreq,
  input  logic             mem_halt,
  input  logic             ex_redirect,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             redirect,
  output logic             redirect_hold,
  output logic             tgt_capture,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t           fsm_q, fsm_d;
  logic             redir_pend_q, redir_pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic dwait;
  logic lu;
  logic redir;

  assign dwait = mem_dreq & ~dhit;
  assign lu    = idex_memread & (idex_rd != 5'd0) &
                 ((idex_rd == ifid_rs) | (idex_rd == ifid_rt));
  assign redir = ex_redirect | redir_pend_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fsm_q        <= ST_RUN;
      redir_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      fsm_q        <= fsm_d;
      redir_pend_q <= redir_pend_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // The pending redirect only moves on a cycle where the redirect path wins;
  // under a data wait EX/MEM is frozen and the same redirect is re-presented.
  always_comb begin
    fsm_d        = fsm_q;
    redir_pend_d = redir_pend_q;
    stall_cnt_d  = stall_cnt_q;
    if (fsm_q == ST_RUN) begin
      if (!pc_en) begin
        stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (mem_halt) begin
        fsm_d = ST_HALT;
      end else if (!dwait && redir) begin
        redir_pend_d = ~ihit;
      end
    end
  end

  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    memwb_flush   = 1'b0;
    redirect      = 1'b0;
    redirect_hold = 1'b0;
    tgt_capture   = 1'b0;
    halted        = 1'b0;
    if (fsm_q == ST_HALT) begin
      halted = 1'b1;
    end else if (mem_halt) begin
      memwb_en = 1'b1;
    end else if (dwait) begin
      memwb_flush = 1'b1;
    end else if (redir) begin
      // Redirect beats load-use: the instruction in ID is wrong-path anyway.
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_en      = 1'b1;
      memwb_en      = 1'b1;
      redirect      = 1'b1;
      pc_en         = ihit;
      redirect_hold = redir_pend_q;
      tgt_capture   = ex_redirect & ~redir_pend_q & ~ihit;
    end else if (lu) begin
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!ihit) begin
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a rule-level reference model.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, mem_dreq = 1'b0, mem_halt = 1'b0;
  logic        ex_redirect = 1'b0, idex_memread = 1'b0;
  logic [4:0]  idex_rd = '0, ifid_rs = '0, ifid_rt = '0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic        redirect, redirect_hold, tgt_capture, halted;
  logic [15:0] stall_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit m_halted;
  bit m_pend;
  int m_cnt;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
    .mem_halt(mem_halt), .ex_redirect(ex_redirect), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .redirect(redirect),
    .redirect_hold(redirect_hold), .tgt_capture(tgt_capture), .halted(halted),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  logic [12:0] obs_vec;
  assign obs_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                    ifid_flush, idex_flush, exmem_flush, memwb_flush,
                    redirect, redirect_hold, tgt_capture, halted};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs straight from the priority rules, same bit order as obs_vec.
  function automatic logic [12:0] model_outs();
    bit pe = 0, fe = 0, de = 0, ee = 0, we = 0, ff = 0, df = 0, ef = 0, wf = 0;
    bit rd = 0, rh = 0, tc = 0, h = 0;
    bit lu;
    lu = idex_memread && idex_rd != 0 && (idex_rd == ifid_rs || idex_rd == ifid_rt);
    if (m_halted) h = 1;
    else if (mem_halt) we = 1;
    else if (mem_dreq && !dhit) wf = 1;
    else if (ex_redirect || m_pend) begin
      ff = 1; df = 1; ee = 1; we = 1; rd = 1; pe = ihit; rh = m_pend;
      tc = ex_redirect && !m_pend && !ihit;
    end else if (lu) begin
      df = 1; ee = 1; we = 1;
    end else if (!ihit) begin
      ff = 1; de = 1; ee = 1; we = 1;
    end else begin
      pe = 1; fe = 1; de = 1; ee = 1; we = 1;
    end
    return {pe, fe, de, ee, we, ff, df, ef, wf, rd, rh, tc, h};
  endfunction

  task automatic model_reset();
    m_halted = 0;
    m_pend   = 0;
    m_cnt    = 0;
  endtask

  // Called at posedge+1; checks the cycle at negedge then advances the model with the edge.
  task automatic step(input logic i_ihit, input logic i_dhit, input logic i_dreq,
                      input logic i_halt, input logic i_exr, input logic i_memrd,
                      input logic [4:0] i_rd, input logic [4:0] i_rs, input logic [4:0] i_rt);
    logic [12:0] exp;
    ihit = i_ihit; dhit = i_dhit; mem_dreq = i_dreq; mem_halt = i_halt;
    ex_redirect = i_exr; idex_memread = i_memrd;
    idex_rd = i_rd; ifid_rs = i_rs; ifid_rt = i_rt;
    @(negedge CLK);
    exp = model_outs();
    chk("outs", 32'(obs_vec), 32'(exp));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    if (!m_halted) begin
      if (!exp[12]) m_cnt = (m_cnt + 1) % 65536;
      if (mem_halt) m_halted = 1;
      else if (!(mem_dreq && !dhit) && (ex_redirect || m_pend)) m_pend = !ihit;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input logic i_ihit);
    step(i_ihit, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // Asserts reset away from any edge, checks the cleared state, releases after the next edge.
  task automatic do_reset();
    ihit = 1; dhit = 0; mem_dreq = 0; mem_halt = 0; ex_redirect = 0; idex_memread = 0;
    idex_rd = '0; ifid_rs = '0; ifid_rt = '0;
    #2;
    nRST = 0;
    model_reset();
    #1;
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    chk("rst_outs", 32'(obs_vec), 32'(13'b11111_0000_0000));
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  initial begin
    model_reset();
    @(posedge CLK);
    #1;
    do_reset();

    // Load-use bubble, then clear
    step(1, 0, 0, 0, 0, 1, 5'd2, 5'd2, 5'd0);
    step(1, 0, 0, 0, 0, 0, 5'd2, 5'd2, 5'd0);
    chk("lu_cnt", 32'(stall_cnt), 32'd1);
    // Load to $0 is not a hazard
    step(1, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    chk("lu_r0_cnt", 32'(stall_cnt), 32'd1);

    // Redirect with fetch hit: no pending state left behind
    step(1, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    idle(1);
    chk("redir_hit_cnt", 32'(stall_cnt), 32'd1);

    // Redirect during a three-cycle fetch wait
    do_reset();
    step(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step(1, 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(1);
    chk("redir_wait_cnt", 32'(stall_cnt), 32'd3);

    // Data wait freezes everything while a redirect is re-presented
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step(1, 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    idle(1);
    chk("dwait_cnt", 32'(stall_cnt), 32'd4);

    // Halt: one drain cycle, then frozen
    step(1, 0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++)
      step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           0, 5'd0, 5'd0, 5'd0);
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_cnt", 32'(stall_cnt), 32'd5);

    // Reset mid-cycle with a pending redirect and halted set
    do_reset();
    step(0, 0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    step(0, 0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    ihit = 0; ex_redirect = 0; mem_halt = 0;
    #2;
    nRST = 0;
    model_reset();
    #1;
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_cnt", 32'(stall_cnt), 32'd0);
    chk("arst_no_redirect", 32'(redirect), 32'd0);
    chk("arst_fetch_wait", 32'(ifid_flush), 32'd1);
    @(posedge CLK);
    #1;
    nRST = 1;
    idle(1);
    chk("arst_run_cnt", 32'(stall_cnt), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      if (n % 75 == 74) do_reset();
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
